// File: rtl/pll_reconf_ctrl.sv
// PLL reconfiguration sequencer: debounces mode_req, drives ROM load / reconfig pulses, then waits for lock.
// Optional macro PLL_RECONF_RETRY_EN re-runs the load/apply sequence on lock timeout, up to MAX_RETRY attempts.
module pll_reconf_ctrl #(
   parameter int MODE_W       = 5,
   parameter int SETTLE_CYC   = 1024,
   parameter int LOCK_TIMEOUT = 65535,
   parameter int MAX_RETRY    = 3
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [MODE_W-1:0] mode_req,
   output logic [MODE_W-1:0] rom_mode,
   output logic              write_from_rom,
   output logic              reconfig,
   input  logic              reconf_busy,
   input  logic              pll_locked,
   output logic              video_hold,
   output logic [MODE_W-1:0] mode_applied,
   output logic              lock_error
);

   localparam int SET_W = $clog2(SETTLE_CYC + 1);
   localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [SET_W-1:0] SET_MAX = SET_W'(SETTLE_CYC);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(LOCK_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_LOAD       = 3'd1,
      S_LOAD_WAIT  = 3'd2,
      S_APPLY      = 3'd3,
      S_APPLY_WAIT = 3'd4,
      S_LOCK       = 3'd5,
      S_FAIL       = 3'd6
   } state_t;

   state_t            state_r, state_nxt;
   logic [MODE_W-1:0] mode_prev_r;
   logic [SET_W-1:0]  settle_cnt_r;
   logic              seen_busy_r;
   logic [3:0]        wait_cnt_r;
   logic [4:0]        lock_cnt_r;
   logic [TMO_W-1:0]  tmo_cnt_r;
   logic              applied_valid_r, valid_nxt;
   logic              fail_block_r, block_nxt;
   logic [MODE_W-1:0] rom_mode_r, rom_mode_nxt;
   logic              write_from_rom_r, wr_nxt;
   logic              reconfig_r, rc_nxt;
   logic              video_hold_r, hold_nxt;
   logic [MODE_W-1:0] mode_applied_r, applied_nxt;
   logic              lock_error_r, err_nxt;

   logic mode_chg_s, settled_s, accept_s, busy_done_s, locked16_s, timeout_s, retry_ok_s;
   logic wait_clr_s, lock_clr_s, tmo_clr_s;

   assign mode_chg_s = (mode_req != mode_prev_r);
   assign settled_s  = !mode_chg_s && (settle_cnt_r == SET_MAX);
   // A failed mode stays blocked until mode_req moves away from it.
   assign accept_s   = settled_s
                     && !(fail_block_r && (mode_req == rom_mode_r))
                     && (!applied_valid_r || (mode_req != mode_applied_r));
   // Busy handshake done: busy seen and now low, or busy never rose within 16 cycles.
   assign busy_done_s = seen_busy_r ? !reconf_busy
                                    : (!reconf_busy && (wait_cnt_r == 4'd15));
   assign locked16_s  = pll_locked && (lock_cnt_r >= 5'd15);
   assign timeout_s   = (tmo_cnt_r == TMO_MAX);

`ifdef PLL_RECONF_RETRY_EN
   localparam int ATT_W = $clog2(MAX_RETRY + 1);
   logic [ATT_W-1:0] attempt_r;

   assign retry_ok_s = (attempt_r < ATT_W'(MAX_RETRY));

   // Attempt counter: restarts at 1 on each accepted request, steps on each lock timeout.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         attempt_r <= '0;
      end else if ((state_r == S_IDLE) && accept_s) begin
         attempt_r <= ATT_W'(1);
      end else if ((state_r == S_LOCK) && !locked16_s && timeout_s && retry_ok_s) begin
         attempt_r <= attempt_r + ATT_W'(1);
      end
   end
`else
   assign retry_ok_s = 1'b0;
`endif

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_nxt    = state_r;
      rom_mode_nxt = rom_mode_r;
      wr_nxt       = 1'b0;
      rc_nxt       = 1'b0;
      hold_nxt     = video_hold_r;
      applied_nxt  = mode_applied_r;
      valid_nxt    = applied_valid_r;
      err_nxt      = lock_error_r;
      block_nxt    = mode_chg_s ? 1'b0 : fail_block_r;
      wait_clr_s   = 1'b0;
      lock_clr_s   = 1'b0;
      tmo_clr_s    = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (accept_s) begin
               rom_mode_nxt = mode_req;
               err_nxt      = 1'b0;
               hold_nxt     = 1'b1;
               block_nxt    = 1'b0;
               lock_clr_s   = 1'b1;
               state_nxt    = S_LOAD;
            end else if (!pll_locked) begin
               hold_nxt = 1'b1;
            end else if (locked16_s && applied_valid_r && !lock_error_r) begin
               hold_nxt = 1'b0;
            end else begin
               hold_nxt = video_hold_r;
            end
         end
         S_LOAD: begin
            if (!reconf_busy) begin
               wr_nxt     = 1'b1;
               wait_clr_s = 1'b1;
               state_nxt  = S_LOAD_WAIT;
            end else begin
               state_nxt = S_LOAD;
            end
         end
         S_LOAD_WAIT: begin
            if (busy_done_s) begin
               state_nxt = S_APPLY;
            end else begin
               state_nxt = S_LOAD_WAIT;
            end
         end
         S_APPLY: begin
            if (!reconf_busy) begin
               rc_nxt     = 1'b1;
               wait_clr_s = 1'b1;
               state_nxt  = S_APPLY_WAIT;
            end else begin
               state_nxt = S_APPLY;
            end
         end
         S_APPLY_WAIT: begin
            if (busy_done_s) begin
               lock_clr_s = 1'b1;
               tmo_clr_s  = 1'b1;
               state_nxt  = S_LOCK;
            end else begin
               state_nxt = S_APPLY_WAIT;
            end
         end
         S_LOCK: begin
            if (locked16_s) begin
               applied_nxt = rom_mode_r;
               valid_nxt   = 1'b1;
               hold_nxt    = 1'b0;
               state_nxt   = S_IDLE;
            end else if (timeout_s && retry_ok_s) begin
               state_nxt = S_LOAD;
            end else if (timeout_s) begin
               state_nxt = S_FAIL;
            end else begin
               state_nxt = S_LOCK;
            end
         end
         S_FAIL: begin
            err_nxt   = 1'b1;
            hold_nxt  = 1'b1;
            block_nxt = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            hold_nxt  = 1'b1;
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Output and status registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rom_mode_r       <= '0;
         write_from_rom_r <= 1'b0;
         reconfig_r       <= 1'b0;
         video_hold_r     <= 1'b1;
         mode_applied_r   <= '0;
         lock_error_r     <= 1'b0;
         applied_valid_r  <= 1'b0;
         fail_block_r     <= 1'b0;
      end else begin
         rom_mode_r       <= rom_mode_nxt;
         write_from_rom_r <= wr_nxt;
         reconfig_r       <= rc_nxt;
         video_hold_r     <= hold_nxt;
         mode_applied_r   <= applied_nxt;
         lock_error_r     <= err_nxt;
         applied_valid_r  <= valid_nxt;
         fail_block_r     <= block_nxt;
      end
   end

   // Settle counter: restarts on any mode_req change, saturates at SETTLE_CYC.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mode_prev_r  <= '0;
         settle_cnt_r <= '0;
      end else begin
         mode_prev_r <= mode_req;
         if (mode_chg_s) begin
            settle_cnt_r <= '0;
         end else if (settle_cnt_r != SET_MAX) begin
            settle_cnt_r <= settle_cnt_r + SET_W'(1);
         end
      end
   end

   // Busy handshake tracker for the two wait states.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         seen_busy_r <= 1'b0;
         wait_cnt_r  <= 4'd0;
      end else if (wait_clr_s) begin
         seen_busy_r <= 1'b0;
         wait_cnt_r  <= 4'd0;
      end else begin
         if (reconf_busy) begin
            seen_busy_r <= 1'b1;
         end
         if (wait_cnt_r != 4'd15) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
         end
      end
   end

   // Consecutive-lock counter (saturating) and lock timeout timer.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lock_cnt_r <= 5'd0;
         tmo_cnt_r  <= '0;
      end else begin
         if (lock_clr_s || !pll_locked) begin
            lock_cnt_r <= 5'd0;
         end else if (lock_cnt_r != 5'd16) begin
            lock_cnt_r <= lock_cnt_r + 5'd1;
         end
         if (tmo_clr_s) begin
            tmo_cnt_r <= '0;
         end else if ((state_r == S_LOCK) && (tmo_cnt_r != TMO_MAX)) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
         end
      end
   end

   assign rom_mode       = rom_mode_r;
   assign write_from_rom = write_from_rom_r;
   assign reconfig       = reconfig_r;
   assign video_hold     = video_hold_r;
   assign mode_applied   = mode_applied_r;
   assign lock_error     = lock_error_r;

endmodule
